sha2_msg_sched_stream: RTL

//  Parametrised SHA-2 message-schedule generator for the double-hash mining datapath.
//  - Accepts one 16-word message block over a valid/ready handshake.
//  - Streams W[0..ROUNDS-1] one word per cycle to the round core, which can stall it.
//  - Generalises the fixed 32-bit, single-step expander stage to SHA-256 or SHA-512 word size,

---
 rtl/sha2_pkg.sv | 66 ++++++
 rtl/sha2_sched_word.sv | 26 ++
 rtl/sha2_msg_sched_stream.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: FSM state type, sigma
// rotate/shift amounts for SHA-256 and SHA-512, the s0/s1 functions,
// the schedule length per word size, and second-hash padding words.
package sha2_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // SHA-256 small-sigma amounts
    localparam int S0_R1_32 = 7;
    localparam int S0_R2_32 = 18;
    localparam int S0_SH_32 = 3;
    localparam int S1_R1_32 = 17;
    localparam int S1_R2_32 = 19;
    localparam int S1_SH_32 = 10;

    // SHA-512 small-sigma amounts
    localparam int S0_R1_64 = 1;
    localparam int S0_R2_64 = 8;
    localparam int S0_SH_64 = 7;
    localparam int S1_R1_64 = 19;
    localparam int S1_R2_64 = 61;
    localparam int S1_SH_64 = 6;

    // Schedule lengths
    localparam int ROUNDS_32 = 64;
    localparam int ROUNDS_64 = 80;

    // Second-hash padding: a lone '1' bit, then the message length in bits
    // (the 8 words of the first digest = 8*WORD_W bits).
    localparam logic [31:0] PAD_MSB_32 = 32'h8000_0000;
    localparam logic [63:0] PAD_MSB_64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] PAD_LEN_32 = 32'h0000_0100;
    localparam logic [63:0] PAD_LEN_64 = 64'h0000_0000_0000_0200;

    function automatic int default_rounds(input int word_w);
        return (word_w == 64) ? ROUNDS_64 : ROUNDS_32;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return rotr32(x, S0_R1_32) ^ rotr32(x, S0_R2_32) ^ (x >> S0_SH_32);
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return rotr32(x, S1_R1_32) ^ rotr32(x, S1_R2_32) ^ (x >> S1_SH_32);
    endfunction

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return rotr64(x, S0_R1_64) ^ rotr64(x, S0_R2_64) ^ (x >> S0_SH_64);
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return rotr64(x, S1_R1_64) ^ rotr64(x, S1_R2_64) ^ (x >> S1_SH_64);
    endfunction

endpackage

// File: rtl/sha2_sched_word.sv
// Combinational message-schedule recurrence:
//   w_new = s1(w14) + w9 + s0(w1) + w0  (mod 2**WORD_W)
// where w0/w1/w9/w14 are the current window slots 0, 1, 9 and 14.
module sha2_sched_word
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] w_new
);

    generate
        if (WORD_W == 32) begin : g_sha256
            // SHA-256 sigma set
            assign w_new = sig1_32(w14) + w9 + sig0_32(w1) + w0;
        end else begin : g_sha512
            // SHA-512 sigma set
            assign w_new = sig1_64(w14) + w9 + sig0_64(w1) + w0;
        end
    endgenerate

endmodule

// File: rtl/sha2_msg_sched_stream.sv
// SHA-2 message-schedule streamer. Accepts one 16-word block and emits
// W[0..ROUNDS-1] one word per transfer, stallable by the consumer.
// Optional feature macro: CME_CONST_PAD_EN adds in_pad, which replaces
// words 8..15 of the block with constant second-hash padding.
//
// Handshake: both ports use valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. Once w_valid is raised,
// w_data/w_idx/w_last stay stable until the transfer. in_ready is high
// in IDLE and also during the final word's transfer, so a new block can
// be loaded in the same cycle the last word leaves. busy is the FSM
// state (1 = RUN) and doubles as the state debug view.
module sha2_msg_sched_stream
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef CME_CONST_PAD_EN
    input  logic                 in_pad,
`endif
    input  logic [16*WORD_W-1:0] in_block,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_data,
    output logic [CNT_W-1:0]     w_idx,
    output logic                 w_last,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    generate
        if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))
            || ROUNDS != default_rounds(WORD_W)) begin : g_bad_cfg
            $error("sha2_msg_sched_stream: illegal WORD_W/ROUNDS pairing");
        end
        if ((2 ** CNT_W) < ROUNDS) begin : g_bad_cnt
            $error("sha2_msg_sched_stream: CNT_W too narrow for ROUNDS");
        end
    endgenerate

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] load_win [16];
    logic [WORD_W-1:0] w_new;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              xfer;

    assign accept = in_valid & in_ready;
    assign xfer   = w_valid & w_ready;

`ifdef CME_CONST_PAD_EN
    logic [WORD_W-1:0] pad_msb;
    logic [WORD_W-1:0] pad_len;

    generate
        if (WORD_W == 32) begin : g_pad32
            assign pad_msb = PAD_MSB_32;
            assign pad_len = PAD_LEN_32;
        end else begin : g_pad64
            assign pad_msb = PAD_MSB_64;
            assign pad_len = PAD_LEN_64;
        end
    endgenerate
`endif

    // Window image to load on accept: W0 from the MSBs, optionally padded
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            load_win[i] = in_block[(15 - i) * WORD_W +: WORD_W];
        end
`ifdef CME_CONST_PAD_EN
        if (in_pad) begin
            load_win[8] = pad_msb;
            for (int i = 9; i < 15; i++) begin
                load_win[i] = '0;
            end
            load_win[15] = pad_len;
        end
`endif
    end

    sha2_sched_word #(
        .WORD_W (WORD_W)
    ) u_word (
        .w0    (win[0]),
        .w1    (win[1]),
        .w9    (win[9]),
        .w14   (win[14]),
        .w_new (w_new)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: stay in RUN across a same-cycle reload
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && w_last) begin
                    state_nxt = accept ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs and handshake
    always_comb begin
        w_valid  = (state == ST_RUN);
        busy     = (state == ST_RUN);
        w_last   = w_valid && (cnt == LAST_IDX);
        in_ready = (state == ST_IDLE) || (w_valid && w_ready && w_last);
        w_data   = win[0];
        w_idx    = cnt;
    end

    // Window and counter: load on accept, slide on transfer, hold on stall
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= load_win[i];
            end
            cnt <= '0;
        end else if (xfer) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= w_new;
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule
